// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with per-register pending-write scoreboard
// and a sequential clear engine that zeroes the array one entry per cycle.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        re,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     clr_req,
    output logic                     ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              w_idle, w_wr, w_iss;

    assign w_idle = (r_state == IDLE);
    assign w_wr   = w_idle & we & !(ZERO_REG && waddr == '0);
    assign w_iss  = w_idle & iss_en & !(ZERO_REG && iss_addr == '0);
    assign ready  = rst & w_idle;

    always_comb begin
        w_next = r_state;
        if (w_idle && clr_req)
            w_next = CLEAR;
        else if (!w_idle && &r_cnt)
            w_next = IDLE;
    end

    // The issue mark is applied after the write so a same-edge new producer keeps the register busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            if (!w_idle) begin
                r_regs[r_cnt] <= '0;
                r_cnt         <= r_cnt + 1'b1;
                r_busy        <= '0;
            end else begin
                if (w_wr) begin
                    r_regs[waddr] <= wdata;
                    r_busy[waddr] <= 1'b0;
                end
                if (w_iss)
                    r_busy[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero, w_byp;
        assign w_ra   = raddr[k*ADDR_W +: ADDR_W];
        assign w_zero = ZERO_REG && w_ra == '0;
        assign w_byp  = we && w_ra == waddr;
        assign rdata[k*DATA_W +: DATA_W] = (!rst || !w_idle || !re[k] || w_zero) ? '0
                                         : w_byp ? wdata : r_regs[w_ra];
        assign rbusy[k] = rst & w_idle & re[k] & r_busy[w_ra] & !w_byp & !w_zero;
    end
endmodule
